// File: rtl/ram_ring_queue_if.sv
// ---------------------------------------------------------------------------
// ram_ring_queue_if
//  Bundles the producer/consumer side of ram_ring_queue.
//  Handshake: a push is offered whenever wr_en is high on a rising edge. A pop
//  is accepted when rd_req is high and empty is low at that edge. The popped
//  word appears on rd_data with rd_valid high for exactly one cycle after the
//  accepting edge.
//  Signals:
//    clr          synchronous flush request
//    mode_ovw     0 = drop pushes when full, 1 = overwrite oldest when full
//    wr_en/wr_data, rd_req               requests from the user side
//    rd_data/rd_valid                    registered pop result
//    full/empty/count                    occupancy view
//    overflow/underflow                  sticky error flags
//    almost_full/almost_empty            present only with RAMQ_ALMOST_EN
//  Modports: master = producer/consumer side, slave = queue side.
// ---------------------------------------------------------------------------
interface ram_ring_queue_if #(
   parameter int WIDTH   = 8,
   parameter int ENTRIES = 384
);
   localparam int CW = $clog2(ENTRIES + 1);

   logic             clr;
   logic             mode_ovw;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;
`ifdef RAMQ_ALMOST_EN
   logic             almost_full;
   logic             almost_empty;

   modport master (
      output clr, mode_ovw, wr_en, wr_data, rd_req,
      input  rd_data, rd_valid, full, empty, count, overflow, underflow,
             almost_full, almost_empty
   );
   modport slave (
      input  clr, mode_ovw, wr_en, wr_data, rd_req,
      output rd_data, rd_valid, full, empty, count, overflow, underflow,
             almost_full, almost_empty
   );
`else
   modport master (
      output clr, mode_ovw, wr_en, wr_data, rd_req,
      input  rd_data, rd_valid, full, empty, count, overflow, underflow
   );
   modport slave (
      input  clr, mode_ovw, wr_en, wr_data, rd_req,
      output rd_data, rd_valid, full, empty, count, overflow, underflow
   );
`endif
endinterface

// File: rtl/ram_ring_queue.sv
// ---------------------------------------------------------------------------
// ram_ring_queue
//  Circular queue on an inferred simple-dual-port RAM with a registered read
//  port. Depth need not be a power of two; the pointers wrap explicitly.
//  Runtime selectable FIFO (drop on full) or overwrite-oldest behaviour.
//  Ports:
//    clk    rising-edge clock
//    rst_n  asynchronous active-low reset
//    q      ram_ring_queue_if.slave (push/pop requests, data, flags, count)
//  Optional feature macro: RAMQ_ALMOST_EN adds almost_full / almost_empty.
// ---------------------------------------------------------------------------
module ram_ring_queue #(
   parameter int WIDTH     = 8,
   parameter int ENTRIES   = 384,
   parameter int AF_MARGIN = 4,
   parameter int AE_MARGIN = 4
) (
   input logic             clk,
   input logic             rst_n,
   ram_ring_queue_if.slave q
);
   localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int CW = $clog2(ENTRIES + 1);

   logic [WIDTH-1:0] mem [ENTRIES];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic full_w, empty_w;
   logic pop_ok, push_ok, ovw_push, mem_we;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(ENTRIES - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full_w  = (count_q == CW'(ENTRIES));
   assign empty_w = (count_q == '0);

   // A push into a full queue is still a normal push when a pop frees a slot
   // on the same edge; otherwise it is either dropped or overwrites the oldest.
   assign pop_ok   = q.rd_req & ~empty_w;
   assign push_ok  = q.wr_en & (~full_w | pop_ok);
   assign ovw_push = q.wr_en & full_w & ~pop_ok & q.mode_ovw;
   assign mem_we   = ~q.clr & (push_ok | ovw_push);

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (q.clr) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         // Overwrite drops the oldest word, so the read pointer moves too.
         if (pop_ok || ovw_push) rptr_d = ptr_inc(rptr_q);
         if (push_ok || ovw_push) wptr_d = ptr_inc(wptr_q);
         rd_valid_d = pop_ok;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (q.wr_en && full_w && !pop_ok) overflow_d = 1'b1;
         if (q.rd_req && empty_w) underflow_d = 1'b1;
      end
   end

   // RAM array: no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wptr_q] <= q.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         // Read-first: on a same-address push+pop the old word is returned.
         if (q.clr)       rd_data_q <= '0;
         else if (pop_ok) rd_data_q <= mem[rptr_q];
      end
   end

   assign q.rd_data   = rd_data_q;
   assign q.rd_valid  = rd_valid_q;
   assign q.full      = full_w;
   assign q.empty     = empty_w;
   assign q.count     = count_q;
   assign q.overflow  = overflow_q;
   assign q.underflow = underflow_q;
`ifdef RAMQ_ALMOST_EN
   assign q.almost_full  = (int'(count_q) >= ENTRIES - AF_MARGIN);
   assign q.almost_empty = (int'(count_q) <= AE_MARGIN);
`endif
endmodule

// File: tb/tb_ram_ring_queue.sv
module tb_ram_ring_queue;
   localparam int W  = 8;
   localparam int N  = 6;
   localparam int NB = 384;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   ram_ring_queue_if #(.WIDTH(W), .ENTRIES(N))  sq ();
   ram_ring_queue_if #(.WIDTH(W), .ENTRIES(NB)) bq ();

   ram_ring_queue #(.WIDTH(W), .ENTRIES(N), .AF_MARGIN(4), .AE_MARGIN(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .q(sq.slave)
   );
   ram_ring_queue #(.WIDTH(W), .ENTRIES(NB)) dut_b (
      .clk(clk), .rst_n(rst_n), .q(bq.slave)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] exp_q[$];     // words expected on rd_data, small queue
   logic [W-1:0] mdl_q[$];     // reference contents, small queue
   logic [W-1:0] exp_b_q[$];
   logic [W-1:0] mdl_b_q[$];
   logic         ovf_m = 1'b0;
   logic         udf_m = 1'b0;
   logic [W-1:0] last_rd = '0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge; drives one cycle, updates the model at the
   // rising edge and checks outputs at the next falling edge.
   task automatic step(logic wr, logic [W-1:0] d, logic rd, logic clr = 1'b0);
      bit pop_ok = 0;
      sq.wr_en = wr; sq.wr_data = d; sq.rd_req = rd; sq.clr = clr;
      @(posedge clk);
      if (clr) begin
         mdl_q.delete();
         ovf_m = 1'b0; udf_m = 1'b0; last_rd = '0;
      end else begin
         if (rd && mdl_q.size() == 0) udf_m = 1'b1;
         if (rd && mdl_q.size() > 0) begin
            pop_ok = 1;
            exp_q.push_back(mdl_q.pop_front());
         end
         if (wr) begin
            if (mdl_q.size() < N) mdl_q.push_back(d);
            else begin
               ovf_m = 1'b1;
               if (sq.mode_ovw) begin
                  void'(mdl_q.pop_front());
                  mdl_q.push_back(d);
               end
            end
         end
      end
      @(negedge clk);
      sq.wr_en = 1'b0; sq.rd_req = 1'b0; sq.clr = 1'b0;
      check("rd_valid", 32'(sq.rd_valid), 32'(pop_ok));
      if (pop_ok) begin
         last_rd = exp_q.pop_front();
         check("rd_data", 32'(sq.rd_data), 32'(last_rd));
      end else begin
         check("rd_hold", 32'(sq.rd_data), 32'(last_rd));
      end
      check("count", 32'(sq.count), mdl_q.size());
      check("full", 32'(sq.full), 32'(mdl_q.size() == N));
      check("empty", 32'(sq.empty), 32'(mdl_q.size() == 0));
      check("overflow", 32'(sq.overflow), 32'(ovf_m));
      check("underflow", 32'(sq.underflow), 32'(udf_m));
`ifdef RAMQ_ALMOST_EN
      check("almost_full", 32'(sq.almost_full), 32'(mdl_q.size() >= N - 4));
      check("almost_empty", 32'(sq.almost_empty), 32'(mdl_q.size() <= 4));
`endif
   endtask

   task automatic step_b(logic wr, logic [W-1:0] d, logic rd);
      bit pop_ok = 0;
      bq.wr_en = wr; bq.wr_data = d; bq.rd_req = rd;
      @(posedge clk);
      if (rd && mdl_b_q.size() > 0) begin
         pop_ok = 1;
         exp_b_q.push_back(mdl_b_q.pop_front());
      end
      if (wr && mdl_b_q.size() < NB) mdl_b_q.push_back(d);
      @(negedge clk);
      bq.wr_en = 1'b0; bq.rd_req = 1'b0;
      check("b_rd_valid", 32'(bq.rd_valid), 32'(pop_ok));
      if (pop_ok) check("b_rd_data", 32'(bq.rd_data), 32'(exp_b_q.pop_front()));
      check("b_count", 32'(bq.count), mdl_b_q.size());
   endtask

   task automatic check_reset_state(string tag);
      check({tag, "_count"}, 32'(sq.count), 0);
      check({tag, "_empty"}, 32'(sq.empty), 1);
      check({tag, "_full"}, 32'(sq.full), 0);
      check({tag, "_rd_valid"}, 32'(sq.rd_valid), 0);
      check({tag, "_rd_data"}, 32'(sq.rd_data), 0);
      check({tag, "_overflow"}, 32'(sq.overflow), 0);
      check({tag, "_underflow"}, 32'(sq.underflow), 0);
      check({tag, "_b_count"}, 32'(bq.count), 0);
`ifdef RAMQ_ALMOST_EN
      check({tag, "_almost_full"}, 32'(sq.almost_full), 0);
      check({tag, "_almost_empty"}, 32'(sq.almost_empty), 1);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      sq.clr = 0; sq.mode_ovw = 0; sq.wr_en = 0; sq.wr_data = '0; sq.rd_req = 0;
      bq.clr = 0; bq.mode_ovw = 0; bq.wr_en = 0; bq.wr_data = '0; bq.rd_req = 0;
      #12 check_reset_state("por");
      #11 rst_n = 1'b1;
      @(negedge clk);

      // 1: basic order
      step(1, 8'h11, 0); step(1, 8'h12, 0); step(1, 8'h13, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      step(0, 0, 0);

      // 2: FIFO mode, push past full
      sq.mode_ovw = 0;
      for (int i = 1; i <= 7; i++) step(1, W'(i), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1);
      step(0, 0, 0, 1);

      // 3: overwrite mode, push past full
      sq.mode_ovw = 1;
      for (int i = 1; i <= 7; i++) step(1, W'(i), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 1);
      step(0, 0, 0, 1);

      // 4: full queue push+pop same cycle, then stream across wrap
      sq.mode_ovw = 0;
      for (int i = 0; i < 6; i++) step(1, W'(8'h21 + i), 0);
      step(1, 8'hAA, 1);
      for (int i = 0; i < 12; i++) step(1, W'($urandom_range(0, 255)), 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1);
      step(0, 0, 0, 1);

      // 5: underflow, no fall-through
      step(0, 0, 1);
      step(1, 8'h55, 1);
      step(0, 0, 1);
      step(0, 0, 0, 1);

      // random mix of push/pop/mode
      for (int i = 0; i < 200; i++) begin
         sq.mode_ovw = 1'($urandom_range(0, 1));
         step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end
      step(0, 0, 0, 1);

      // default depth: fill, stream across wrap, drain
      for (int i = 0; i < NB; i++) step_b(1, W'(i ^ 8'h5A), 0);
      check("b_full", 32'(bq.full), 1);
      for (int i = 0; i < 12; i++) step_b(1, W'($urandom_range(0, 255)), 1);
      for (int i = 0; i < NB; i++) step_b(0, 0, 1);
      check("b_empty", 32'(bq.empty), 1);

      // 6: async reset mid-cycle with data queued
      for (int i = 0; i < 3; i++) step(1, W'(8'h31 + i), 0);
      step(0, 0, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_state("async_rst");
      mdl_q.delete(); exp_q.delete(); ovf_m = 0; udf_m = 0; last_rd = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1, W'(8'h41 + i), 0);
      step(1, 8'h99, 1, 1);
      step(1, 8'h77, 0);
      step(0, 0, 1);
      step(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
